monitor_alu: RTL and testbench
==============================

// Module: monitor_alu
// PURPOSE
//   Receiving end of the ALU stimulus interface: samples operands/op driven into the ALU and
//   the ALU result, runs a 32-bit reference model, compares and keeps pass/error statistics.
//   Sits in the ALU bench beside the stimulus driver; result path may be pipelined (LATENCY).
//   Run-controlled by i_start; reports o_done after N_CHECKS comparisons.
// PARAMETERS
//   LATENCY   0     cycles from operands sampled to result valid at DUT output (0..8)
//   N_CHECKS  1000  comparisons per run (>=1)
//   CNT_W     32    width of statistic counters
// PORTS
//   i_clk           in   1      clock; all sampling on rising edge
//   i_rst_n         in   1      reset, asynchronous, active-low
//   i_start         in   1      pulse: begin a run (accepted in IDLE or DONE only)
//   i_operand_a     in   32     operand A as driven to ALU
//   i_operand_b     in   32     operand B as driven to ALU
//   i_alu_op        in   ALUSel_e  operation as driven to ALU (singlecycle_pkg)
//   i_alu_data      in   32     ALU result
//   o_busy          out  1      run in progress (FILL or CHECK)
//   o_done          out  1      run finished; held until next i_start or reset
//   o_pass_cnt      out  CNT_W  matching comparisons
//   o_err_cnt       out  CNT_W  mismatching comparisons
//   o_skip_cnt      out  CNT_W  samples with op outside the 10 supported encodings
//   o_first_err_vld out  1      a first mismatch has been captured this run
//   o_first_err_op  out  ALUSel_e op of first mismatch
//   o_first_err_exp out  32     expected value of first mismatch
//   o_first_err_got out  32     observed value of first mismatch
// BEHAVIOUR
//   Reset: state IDLE; all counters 0; o_busy=0, o_done=0, o_first_err_* = 0 (op = ALU_ADD).
//   Reset is honoured at any time, incl. mid-run: run aborts, no partial results kept.
//   FSM: IDLE -start-> FILL (LATENCY>0) or CHECK (LATENCY=0); FILL -LATENCY samples-> CHECK;
//        CHECK -N_CHECKS-th comparison-> DONE; DONE -start-> FILL/CHECK. i_start ignored
//        while busy. Accepting start clears all counters and o_first_err_*, drops o_done.
//   Sampling: every edge while busy, {a,b,op} shift into a LATENCY-deep delay line; the
//        entry leaving the line is paired with i_alu_data on that same edge. LATENCY=0 pairs
//        inputs and result sampled on the same edge. The start edge itself is sample #0.
//   Model (32-bit, wrap-around): ADD a+b; SUB a-b; XOR; OR; AND; SLL a<<b[4:0];
//        SRL a>>b[4:0] (zero fill); SRA a>>>b[4:0] (sign fill); SLT signed(a)<signed(b) ? 1:0;
//        SLTU unsigned compare ? 1:0. Upper bits of b ignored for shifts.
//   Compare uses 4-state equality: any X/Z bit in i_alu_data is a mismatch.
//   Unsupported op: o_skip_cnt++, no compare, but still counts toward N_CHECKS.
//   Per compare exactly one of pass/err/skip increments; counters saturate at all-ones.
//   First mismatch of a run latched into o_first_err_*; later mismatches only count.
//   o_done rises one cycle after the N_CHECKS-th compare edge; o_busy falls same cycle.
// TESTING
//   1 LATENCY=0, ADD a=FFFFFFFF b=00000001, DUT=00000000 -> pass_cnt=1, err_cnt=0.
//   2 SRA a=80000000 b=00000024 (shift 4) DUT=F8000000 -> pass; SRL same -> expects 08000000.
//   3 SLT a=FFFFFFFF b=00000001 DUT=1 -> pass; SLTU same operands DUT=1 -> err, exp=0 got=1.
//   4 N_CHECKS=100 random run, flip bit0 of result on checks 10 and 50 -> err_cnt=2,
//     pass_cnt=98, first_err_* from check 10, o_done high after 100th compare.
//   5 LATENCY=2 with 2-stage delayed ALU result -> err_cnt=0; LATENCY=1 vs same DUT -> errors.
//   6 i_rst_n low mid-run (check 37) -> counters 0, IDLE; new start -> full N_CHECKS run.

Source files
------------

// File: rtl/monitor_alu.sv
// monitor_alu: ALU result checker with a 32-bit reference model and run statistics.
//   i_clk, i_rst_n (async, active-low), i_start (begins a run from IDLE/DONE)
//   i_operand_a/b, i_alu_op, i_alu_data: operands and op driven into the ALU, and the ALU result
//   o_busy/o_done: run status; o_pass/err/skip_cnt: saturating statistics
//   o_first_err_*: op, expected and observed value of the first mismatch of the run
module monitor_alu #(
  parameter int LATENCY  = 0,
  parameter int N_CHECKS = 1000,
  parameter int CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_operand_a,
  input  logic [31:0]      i_operand_b,
  input  logic [3:0]       i_alu_op,
  input  logic [31:0]      i_alu_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_skip_cnt,
  output logic             o_first_err_vld,
  output logic [3:0]       o_first_err_op,
  output logic [31:0]      o_first_err_exp,
  output logic [31:0]      o_first_err_got
);
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam int D  = LATENCY > 0 ? LATENCY : 1;
  localparam int CW = $clog2(N_CHECKS + 1);
  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_e;
  state_e state_q, state_d;
  logic [67:0] dly_q [D];
  logic [D-1:0] vld_q, vld_d;
  logic [CW-1:0] chk_q, chk_d, chk_b;
  logic [CNT_W-1:0] pass_q, pass_d, pass_b, err_q, err_d, err_b, skip_q, skip_d, skip_b;
  logic fe_vld_q, fe_vld_d, fe_vld_b;
  logic [3:0] fe_op_q, fe_op_d;
  logic [31:0] fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;
  logic [67:0] sample;
  logic [31:0] op_a, op_b, exp;
  logic [3:0] op_sel;
  logic [4:0] sh;
  logic busy, start_acc, smp, cmp, supported, mismatch, last;
  always_comb begin
    sample    = {i_operand_a, i_operand_b, i_alu_op};
    busy      = state_q == FILL || state_q == CHECK;
    start_acc = i_start && !busy;
    smp       = busy || start_acc;
    // Delay-line output is stale on the start edge, so only LATENCY=0 compares there.
    {op_a, op_b, op_sel} = LATENCY == 0 ? sample : dly_q[D-1];
    cmp       = smp && (LATENCY == 0 || (!start_acc && vld_q[D-1]));
    sh        = op_b[4:0];
    exp       = '0;
    case (op_sel)
      ALU_ADD:  exp = op_a + op_b;
      ALU_SUB:  exp = op_a - op_b;
      ALU_XOR:  exp = op_a ^ op_b;
      ALU_OR:   exp = op_a | op_b;
      ALU_AND:  exp = op_a & op_b;
      ALU_SLL:  exp = op_a << sh;
      ALU_SRL:  exp = op_a >> sh;
      ALU_SRA:  exp = 32'($signed(op_a) >>> sh);
      ALU_SLT:  exp = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: exp = {31'd0, op_a < op_b};
      default:  exp = '0;
    endcase
    supported = op_sel <= ALU_SLTU;
    // Case inequality so X/Z in the observed result counts as a mismatch.
    mismatch  = i_alu_data !== exp;
    chk_b     = start_acc ? '0 : chk_q;
    pass_b    = start_acc ? '0 : pass_q;
    err_b     = start_acc ? '0 : err_q;
    skip_b    = start_acc ? '0 : skip_q;
    fe_vld_b  = start_acc ? 1'b0 : fe_vld_q;
    last      = cmp && chk_b == CW'(N_CHECKS - 1);
    chk_d     = cmp ? chk_b + 1'b1 : chk_b;
    pass_d    = (cmp && supported && !mismatch && !(&pass_b)) ? pass_b + 1'b1 : pass_b;
    err_d     = (cmp && supported && mismatch && !(&err_b)) ? err_b + 1'b1 : err_b;
    skip_d    = (cmp && !supported && !(&skip_b)) ? skip_b + 1'b1 : skip_b;
    fe_vld_d  = fe_vld_b || (cmp && supported && mismatch);
    fe_op_d   = (cmp && supported && mismatch && !fe_vld_b) ? op_sel : start_acc ? ALU_ADD : fe_op_q;
    fe_exp_d  = (cmp && supported && mismatch && !fe_vld_b) ? exp : start_acc ? '0 : fe_exp_q;
    fe_got_d  = (cmp && supported && mismatch && !fe_vld_b) ? i_alu_data : start_acc ? '0 : fe_got_q;
    // Valid bits track which delay-line entries belong to the current run.
    vld_d     = smp ? (((start_acc ? '0 : vld_q) << 1) | D'(1)) : vld_q;
    state_d   = last ? DONE : smp ? ((LATENCY == 0 || vld_d[D-1]) ? CHECK : FILL) : state_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      chk_q    <= '0;
      pass_q   <= '0;
      err_q    <= '0;
      skip_q   <= '0;
      fe_vld_q <= 1'b0;
      fe_op_q  <= ALU_ADD;
      fe_exp_q <= '0;
      fe_got_q <= '0;
      for (int i = 0; i < D; i++) dly_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      chk_q    <= chk_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      skip_q   <= skip_d;
      fe_vld_q <= fe_vld_d;
      fe_op_q  <= fe_op_d;
      fe_exp_q <= fe_exp_d;
      fe_got_q <= fe_got_d;
      if (smp) begin
        dly_q[0] <= sample;
        for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
      end
    end
  assign o_busy          = busy;
  assign o_done          = state_q == DONE;
  assign o_pass_cnt      = pass_q;
  assign o_err_cnt       = err_q;
  assign o_skip_cnt      = skip_q;
  assign o_first_err_vld = fe_vld_q;
  assign o_first_err_op  = fe_op_q;
  assign o_first_err_exp = fe_exp_q;
  assign o_first_err_got = fe_got_q;
endmodule

// File: tb/tb_monitor_alu.sv
// tb_monitor_alu: randomized and directed checks of monitor_alu against a behavioural ALU model.
module tb_monitor_alu;
  logic clk = 0, rst_n = 1, start = 0;
  logic [31:0] a = 0, b = 0, d0 = 0, dp, p1 = 0, p2 = 0;
  logic [3:0] op = 0;
  int checks = 0, errors = 0;
  logic m0_busy, m0_done, m0_fev, m1_busy, m1_done, m1_fev, m2_busy, m2_done, m2_fev, m3_busy, m3_done, m3_fev;
  logic [31:0] m0_pass, m0_err, m0_skip, m1_pass, m1_err, m1_skip, m2_pass, m2_err, m2_skip;
  logic [1:0] m3_pass, m3_err, m3_skip;
  logic [3:0] m0_feop, m1_feop, m2_feop, m3_feop;
  logic [31:0] m0_feexp, m0_fegot, m1_feexp, m1_fegot, m2_feexp, m2_fegot, m3_feexp, m3_fegot;

  always #5 clk = ~clk;

  function automatic logic [31:0] model_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int unsigned s = int'(y % 32);
    case (o)
      0: return x + y;
      1: return x - y;
      2: return x ^ y;
      3: return x | y;
      4: return x & y;
      5: return x << s;
      6: return x >> s;
      7: return 32'($signed(x) >>> s);
      8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      9: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Emulated ALU with a two-stage pipelined result path.
  always @(posedge clk) begin
    p1 <= model_alu(op, a, b);
    p2 <= p1;
  end
  assign dp = p2;

  monitor_alu #(.LATENCY(0), .N_CHECKS(100), .CNT_W(32)) m0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_operand_a(a), .i_operand_b(b), .i_alu_op(op),
    .i_alu_data(d0), .o_busy(m0_busy), .o_done(m0_done), .o_pass_cnt(m0_pass), .o_err_cnt(m0_err),
    .o_skip_cnt(m0_skip), .o_first_err_vld(m0_fev), .o_first_err_op(m0_feop),
    .o_first_err_exp(m0_feexp), .o_first_err_got(m0_fegot));
  monitor_alu #(.LATENCY(1), .N_CHECKS(100), .CNT_W(32)) m1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_operand_a(a), .i_operand_b(b), .i_alu_op(op),
    .i_alu_data(dp), .o_busy(m1_busy), .o_done(m1_done), .o_pass_cnt(m1_pass), .o_err_cnt(m1_err),
    .o_skip_cnt(m1_skip), .o_first_err_vld(m1_fev), .o_first_err_op(m1_feop),
    .o_first_err_exp(m1_feexp), .o_first_err_got(m1_fegot));
  monitor_alu #(.LATENCY(2), .N_CHECKS(100), .CNT_W(32)) m2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_operand_a(a), .i_operand_b(b), .i_alu_op(op),
    .i_alu_data(dp), .o_busy(m2_busy), .o_done(m2_done), .o_pass_cnt(m2_pass), .o_err_cnt(m2_err),
    .o_skip_cnt(m2_skip), .o_first_err_vld(m2_fev), .o_first_err_op(m2_feop),
    .o_first_err_exp(m2_feexp), .o_first_err_got(m2_fegot));
  monitor_alu #(.LATENCY(0), .N_CHECKS(8), .CNT_W(2)) m3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_operand_a(a), .i_operand_b(b), .i_alu_op(op),
    .i_alu_data(d0), .o_busy(m3_busy), .o_done(m3_done), .o_pass_cnt(m3_pass), .o_err_cnt(m3_err),
    .o_skip_cnt(m3_skip), .o_first_err_vld(m3_fev), .o_first_err_op(m3_feop),
    .o_first_err_exp(m3_feexp), .o_first_err_got(m3_fegot));

  task automatic do_reset();
    start = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m0_busy !== 1'b0 || m0_done !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%b done=%b exp 0 0", m0_busy, m0_done); end
    checks++; if (m0_pass !== 0 || m0_err !== 0 || m0_skip !== 0) begin errors++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0", m0_pass, m0_err, m0_skip); end
    checks++; if (m0_fev !== 1'b0 || m0_feop !== 4'd0 || m0_feexp !== 0 || m0_fegot !== 0) begin errors++; $display("FAIL reset_first_err got vld=%b op=%0d exp=%h got=%h exp all 0", m0_fev, m0_feop, m0_feexp, m0_fegot); end
    checks++; if (m2_busy !== 1'b0 || m2_done !== 1'b0) begin errors++; $display("FAIL reset_lat2 got busy=%b done=%b exp 0 0", m2_busy, m2_done); end
  endtask

  task automatic test_directed();
    logic [3:0]  vop [7] = '{4'd0, 4'd7, 4'd6, 4'd8, 4'd9, 4'hC, 4'd0};
    logic [31:0] va  [7] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h5};
    logic [31:0] vb  [7] = '{32'h1, 32'h24, 32'h24, 32'h1, 32'h1, 32'h2, 32'h6};
    logic [31:0] vd  [7] = '{32'h0, 32'hF8000000, 32'h08000000, 32'h1, 32'h1, 32'h0, 32'hxxxxxxxx};
    for (int i = 0; i < 7; i++) begin
      logic [31:0] e;
      logic sup, bad;
      do_reset();
      op = vop[i]; a = va[i]; b = vb[i]; d0 = vd[i]; start = 1;
      @(negedge clk);
      start = 0;
      e = model_alu(vop[i], va[i], vb[i]);
      sup = vop[i] <= 4'd9;
      bad = sup && (vd[i] !== e);
      checks++; if (m0_pass !== 32'(sup && !bad) || m0_err !== 32'(bad) || m0_skip !== 32'(!sup)) begin errors++; $display("FAIL directed%0d_cnt got %0d/%0d/%0d exp %0d/%0d/%0d", i, m0_pass, m0_err, m0_skip, sup && !bad, bad, !sup); end
      checks++; if (m0_fev !== bad) begin errors++; $display("FAIL directed%0d_fev got %b exp %b", i, m0_fev, bad); end
      if (bad) begin
        checks++; if (m0_feop !== vop[i] || m0_feexp !== e || m0_fegot !== vd[i]) begin errors++; $display("FAIL directed%0d_first_err got op=%0d exp=%h got=%h exp op=%0d exp=%h got=%h", i, m0_feop, m0_feexp, m0_fegot, vop[i], e, vd[i]); end
      end
    end
  endtask

  task automatic test_random_run();
    logic [3:0] fop = 0;
    logic [31:0] fexp = 0;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      op = 4'($urandom_range(0, 9)); a = $urandom; b = $urandom;
      d0 = model_alu(op, a, b) ^ ((k == 9 || k == 49) ? 32'd1 : 32'd0);
      if (k == 9) begin fop = op; fexp = model_alu(op, a, b); end
      start = (k == 0);
      @(negedge clk);
      if (k == 98) begin
        checks++; if (m0_busy !== 1'b1 || m0_done !== 1'b0) begin errors++; $display("FAIL run_before_last got busy=%b done=%b exp 1 0", m0_busy, m0_done); end
      end
    end
    start = 0;
    checks++; if (m0_busy !== 1'b0 || m0_done !== 1'b1) begin errors++; $display("FAIL run_done got busy=%b done=%b exp 0 1", m0_busy, m0_done); end
    checks++; if (m0_pass !== 32'd98 || m0_err !== 32'd2 || m0_skip !== 0) begin errors++; $display("FAIL run_cnt got %0d/%0d/%0d exp 98/2/0", m0_pass, m0_err, m0_skip); end
    checks++; if (m0_fev !== 1'b1 || m0_feop !== fop || m0_feexp !== fexp || m0_fegot !== (fexp ^ 32'd1)) begin errors++; $display("FAIL run_first_err got op=%0d exp=%h got=%h exp op=%0d exp=%h got=%h", m0_feop, m0_feexp, m0_fegot, fop, fexp, fexp ^ 32'd1); end
    repeat (3) @(negedge clk);
    checks++; if (m0_done !== 1'b1 || m0_pass !== 32'd98) begin errors++; $display("FAIL run_hold got done=%b pass=%0d exp 1 98", m0_done, m0_pass); end
    op = 4'd1; a = 32'd10; b = 32'd3; d0 = 32'd7; start = 1;
    @(negedge clk);
    start = 0;
    checks++; if (m0_pass !== 32'd1 || m0_err !== 0 || m0_fev !== 1'b0 || m0_done !== 1'b0 || m0_busy !== 1'b1) begin errors++; $display("FAIL restart got pass=%0d err=%0d fev=%b done=%b busy=%b exp 1 0 0 0 1", m0_pass, m0_err, m0_fev, m0_done, m0_busy); end
  endtask

  task automatic test_latency();
    logic [31:0] sa [102], sb [102], dk [102];
    logic [3:0] so [102];
    int ep [3], ee [3], es [3];
    do_reset();
    for (int k = 0; k < 102; k++) begin
      op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
      sa[k] = a; sb[k] = b; so[k] = op; dk[k] = dp;
      start = (k == 0);
      @(negedge clk);
    end
    start = 0;
    for (int l = 1; l <= 2; l++) begin
      ep[l] = 0; ee[l] = 0; es[l] = 0;
      for (int j = 0; j < 100; j++)
        if (so[j] > 4'd9) es[l]++;
        else if (dk[j+l] === model_alu(so[j], sa[j], sb[j])) ep[l]++;
        else ee[l]++;
    end
    checks++; if (m2_pass !== 32'(ep[2]) || m2_err !== 32'(ee[2]) || m2_skip !== 32'(es[2])) begin errors++; $display("FAIL lat2_cnt got %0d/%0d/%0d exp %0d/%0d/%0d", m2_pass, m2_err, m2_skip, ep[2], ee[2], es[2]); end
    checks++; if (m2_err !== 0) begin errors++; $display("FAIL lat2_matched got err=%0d exp 0", m2_err); end
    checks++; if (m1_pass !== 32'(ep[1]) || m1_err !== 32'(ee[1]) || m1_skip !== 32'(es[1])) begin errors++; $display("FAIL lat1_cnt got %0d/%0d/%0d exp %0d/%0d/%0d", m1_pass, m1_err, m1_skip, ep[1], ee[1], es[1]); end
    checks++; if (m1_done !== 1'b1 || m2_done !== 1'b1 || m2_busy !== 1'b0) begin errors++; $display("FAIL lat_done got d1=%b d2=%b b2=%b exp 1 1 0", m1_done, m2_done, m2_busy); end
  endtask

  task automatic test_mid_reset();
    int ep = 0, es = 0, ep8 = 0, es8 = 0;
    do_reset();
    for (int k = 0; k < 37; k++) begin
      op = 4'($urandom_range(0, 9)); a = $urandom; b = $urandom; d0 = model_alu(op, a, b);
      start = (k == 0);
      @(negedge clk);
    end
    start = 0;
    checks++; if (m0_pass !== 32'd37 || m0_busy !== 1'b1) begin errors++; $display("FAIL mid_before got pass=%0d busy=%b exp 37 1", m0_pass, m0_busy); end
    rst_n = 0;
    #1;
    checks++; if (m0_pass !== 0 || m0_err !== 0 || m0_skip !== 0 || m0_busy !== 1'b0 || m0_done !== 1'b0) begin errors++; $display("FAIL mid_reset got pass=%0d err=%0d skip=%0d busy=%b done=%b exp all 0", m0_pass, m0_err, m0_skip, m0_busy, m0_done); end
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 100; k++) begin
      op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; d0 = model_alu(op, a, b);
      if (op > 4'd9) es++; else ep++;
      if (k == 7) begin ep8 = ep; es8 = es; end
      start = (k == 0);
      @(negedge clk);
    end
    start = 0;
    checks++; if (m0_pass !== 32'(ep) || m0_skip !== 32'(es) || m0_err !== 0 || m0_done !== 1'b1) begin errors++; $display("FAIL full_run got %0d/%0d/%0d done=%b exp %0d/0/%0d 1", m0_pass, m0_err, m0_skip, m0_done, ep, es); end
    checks++; if (m3_pass !== 2'(ep8 > 3 ? 3 : ep8) || m3_skip !== 2'(es8 > 3 ? 3 : es8) || m3_done !== 1'b1) begin errors++; $display("FAIL saturate got pass=%0d skip=%0d done=%b exp %0d %0d 1", m3_pass, m3_skip, m3_done, ep8 > 3 ? 3 : ep8, es8 > 3 ? 3 : es8); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_run();
    test_latency();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
